// File: rtl/pulse_interval_monitor.sv
// Per-window rising-edge count and min/max edge-to-edge interval of a pulse stream,
// published through snapshot registers with a valid/ack handshake and sticky overrun.
module pulse_interval_monitor #(
  parameter int CNT_W  = 16,
  parameter int WINDOW = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             pulse_in,
  input  logic             result_ack,
  output logic [CNT_W-1:0] count_out,
  output logic [CNT_W-1:0] min_out,
  output logic [CNT_W-1:0] max_out,
  output logic             result_valid,
  output logic             overrun
);
  localparam logic [0:0]       IDLE     = 1'b0;
  localparam logic [0:0]       RUN      = 1'b1;
  localparam logic [CNT_W-1:0] ONES     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WINDOW - 1);

  logic [0:0]       state;
  logic             pulse_d, has_prev;
  logic [CNT_W-1:0] win_cnt, iv_cnt, acc_cnt, acc_min, acc_max;
  logic             pulse_edge, rec, snap;
  logic [CNT_W-1:0] cnt_nxt, min_nxt, max_nxt;

  // Post-update accumulator values; these are what a snapshot captures on the last window cycle.
  always_comb begin
    pulse_edge = (state == RUN) && ena && pulse_in && !pulse_d;
    rec        = pulse_edge && has_prev;
    snap       = (state == RUN) && ena && (win_cnt == WIN_LAST);
    cnt_nxt    = acc_cnt;
    if (pulse_edge && acc_cnt != ONES) cnt_nxt = acc_cnt + CNT_W'(1);
    min_nxt    = (rec && iv_cnt < acc_min) ? iv_cnt : acc_min;
    max_nxt    = (rec && iv_cnt > acc_max) ? iv_cnt : acc_max;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pulse_d  <= 1'b0;
      has_prev <= 1'b0;
      win_cnt  <= '0;
      iv_cnt   <= '0;
      acc_cnt  <= '0;
      acc_min  <= ONES;
      acc_max  <= '0;
    end else begin
      pulse_d <= pulse_in;
      case (state)
        IDLE: if (ena) state <= RUN;
        RUN: begin
          if (!ena) begin
            state    <= IDLE;
            has_prev <= 1'b0;
            win_cnt  <= '0;
            iv_cnt   <= '0;
            acc_cnt  <= '0;
            acc_min  <= ONES;
            acc_max  <= '0;
          end else begin
            // Interval counter and has_prev run across window boundaries.
            if (pulse_edge) begin
              iv_cnt   <= CNT_W'(1);
              has_prev <= 1'b1;
            end else if (iv_cnt != ONES) begin
              iv_cnt <= iv_cnt + CNT_W'(1);
            end
            if (snap) begin
              win_cnt <= '0;
              acc_cnt <= '0;
              acc_min <= ONES;
              acc_max <= '0;
            end else begin
              win_cnt <= win_cnt + CNT_W'(1);
              acc_cnt <= cnt_nxt;
              acc_min <= min_nxt;
              acc_max <= max_nxt;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_out    <= '0;
      min_out      <= '0;
      max_out      <= '0;
      result_valid <= 1'b0;
      overrun      <= 1'b0;
    end else if (snap) begin
      count_out    <= cnt_nxt;
      min_out      <= min_nxt;
      max_out      <= max_nxt;
      result_valid <= 1'b1;
      // A same-cycle ack consumed the old snapshot, so nothing was lost.
      if (result_ack)        overrun <= 1'b0;
      else if (result_valid) overrun <= 1'b1;
    end else if (result_ack && result_valid) begin
      result_valid <= 1'b0;
      overrun      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pulse_interval_monitor.sv
// Drives two monitor instances (16-bit/100-cycle and 4-bit/15-cycle) with shared stimulus
// and compares them against a window/edge-list reference model.
module tb_pulse_interval_monitor;
  logic clk = 1'b0;
  logic rst, ena, pulse_in, result_ack;
  logic [15:0] c0, mn0, mx0;
  logic        v0, o0;
  logic [3:0]  c1, mn1, mx1;
  logic        v1, o1;

  always #5 clk = ~clk;

  pulse_interval_monitor #(.CNT_W(16), .WINDOW(100)) u0 (
    .clk(clk), .rst(rst), .ena(ena), .pulse_in(pulse_in), .result_ack(result_ack),
    .count_out(c0), .min_out(mn0), .max_out(mx0), .result_valid(v0), .overrun(o0));

  pulse_interval_monitor #(.CNT_W(4), .WINDOW(15)) u1 (
    .clk(clk), .rst(rst), .ena(ena), .pulse_in(pulse_in), .result_ack(result_ack),
    .count_out(c1), .min_out(mn1), .max_out(mx1), .result_valid(v1), .overrun(o1));

  wire [49:0] obs0 = {v0, o0, c0, mn0, mx0};
  wire [13:0] obs1 = {v1, o1, c1, mn1, mx1};

  // Reference model: edge times since RUN entry; windows evaluated from the edge list.
  int  win_len[2] = '{100, 15};
  int  sat_max[2] = '{65535, 15};
  bit  m_run, m_prev;
  int  m_t;
  int  eq[$];
  bit  e_vld[2], e_ovr[2];
  int  e_cnt[2], e_min[2], e_max[2];
  logic [49:0] exp0;
  logic [13:0] exp1;
  int  vectors, miscompares;

  always_comb begin
    exp0 = {e_vld[0], e_ovr[0], e_cnt[0][15:0], e_min[0][15:0], e_max[0][15:0]};
    exp1 = {e_vld[1], e_ovr[1], e_cnt[1][3:0], e_min[1][3:0], e_max[1][3:0]};
  end

  task automatic model_reset();
    m_run = 0; m_prev = 0; m_t = 0;
    eq.delete();
    for (int d = 0; d < 2; d++) begin
      e_vld[d] = 0; e_ovr[d] = 0; e_cnt[d] = 0; e_min[d] = 0; e_max[d] = 0;
    end
  endtask

  task automatic step(input bit en, input bit p, input bit ak);
    bit snap[2];
    int cnt[2], mn[2], mx[2];
    ena = en; pulse_in = p; result_ack = ak;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      snap = '{0, 0};
      if (m_run) begin
        if (!en) begin
          m_run = 0;
          eq.delete();
        end else begin
          if (p && !m_prev) eq.push_back(m_t);
          for (int d = 0; d < 2; d++) begin
            if (m_t % win_len[d] == win_len[d] - 1) begin
              int lo;
              lo = m_t - win_len[d] + 1;
              snap[d] = 1; cnt[d] = 0; mn[d] = sat_max[d]; mx[d] = 0;
              for (int i = 0; i < eq.size(); i++) begin
                if (eq[i] >= lo) begin
                  cnt[d]++;
                  if (i > 0) begin
                    int iv;
                    iv = eq[i] - eq[i-1];
                    if (iv > sat_max[d]) iv = sat_max[d];
                    if (iv < mn[d]) mn[d] = iv;
                    if (iv > mx[d]) mx[d] = iv;
                  end
                end
              end
              if (cnt[d] > sat_max[d]) cnt[d] = sat_max[d];
            end
          end
          m_t++;
        end
      end else if (en) begin
        m_run = 1;
        m_t = 0;
      end
      for (int d = 0; d < 2; d++) begin
        if (snap[d]) begin
          if (ak) e_ovr[d] = 0;
          else if (e_vld[d]) e_ovr[d] = 1;
          e_vld[d] = 1; e_cnt[d] = cnt[d]; e_min[d] = mn[d]; e_max[d] = mx[d];
        end else if (ak && e_vld[d]) begin
          e_vld[d] = 0; e_ovr[d] = 0;
        end
      end
      m_prev = p;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1;
    step(0, 0, 0);
    step(0, 0, 0);
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    step(0, 0, 0);
    if (obs0 !== 50'd0) begin miscompares++; $display("FAIL reset u0 got %h want 0", obs0); end
    vectors++;
    if (obs1 !== 14'd0) begin miscompares++; $display("FAIL reset u1 got %h want 0", obs1); end
    vectors++;
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      step(0, 1'(i == 1), 1'(i == 2));
      if (obs0 !== exp0) begin miscompares++; $display("FAIL idle u0 got %h want %h", obs0, exp0); end
      vectors++;
    end
  endtask

  task automatic test_periodic();
    do_reset();
    step(1, 0, 0);
    for (int t = 0; t < 200; t++) begin
      step(1, 1'(t % 10 == 5), 1'(t == 110));
      if (obs0 !== exp0) begin miscompares++; $display("FAIL periodic u0 t=%0d got %h want %h", t, obs0, exp0); end
      vectors++;
      if (obs1 !== exp1) begin miscompares++; $display("FAIL periodic u1 t=%0d got %h want %h", t, obs1, exp1); end
      vectors++;
      if (t == 99 || t == 199) begin
        if ({v0, c0, mn0, mx0} !== {1'b1, 16'd10, 16'd10, 16'd10}) begin
          miscompares++;
          $display("FAIL periodic_win t=%0d got v=%0d cnt=%0d min=%0d max=%0d want 1/10/10/10", t, v0, c0, mn0, mx0);
        end
        vectors++;
      end
    end
  endtask

  task automatic test_empty();
    do_reset();
    step(1, 0, 0);
    for (int t = 0; t < 100; t++) step(1, 0, 0);
    if (obs0 !== {1'b1, 1'b0, 16'd0, 16'hFFFF, 16'd0}) begin
      miscompares++; $display("FAIL empty u0 got %h want %h", obs0, {1'b1, 1'b0, 16'd0, 16'hFFFF, 16'd0});
    end
    vectors++;
    if (obs0 !== exp0) begin miscompares++; $display("FAIL empty_model u0 got %h want %h", obs0, exp0); end
    vectors++;
  endtask

  task automatic test_level();
    bit p;
    do_reset();
    step(1, 0, 0);
    for (int t = 0; t < 100; t++) begin
      p = (t >= 10 && t < 12) || (t >= 13 && t < 18) || (t >= 20 && t < 25);
      step(1, p, 0);
    end
    if ({v0, c0, mn0, mx0} !== {1'b1, 16'd3, 16'd3, 16'd7}) begin
      miscompares++; $display("FAIL level got cnt=%0d min=%0d max=%0d want 3/3/7", c0, mn0, mx0);
    end
    vectors++;
    if (obs0 !== exp0) begin miscompares++; $display("FAIL level_model u0 got %h want %h", obs0, exp0); end
    vectors++;
  endtask

  task automatic test_overrun();
    do_reset();
    step(1, 0, 0);
    for (int t = 0; t < 400; t++) begin
      step(1, 1'($urandom_range(0, 3) == 0), 1'(t == 200 || t == 399));
      if (obs0 !== exp0) begin miscompares++; $display("FAIL overrun u0 t=%0d got %h want %h", t, obs0, exp0); end
      vectors++;
      if (t == 199 && {v0, o0} !== 2'b11) begin
        miscompares++; $display("FAIL overrun_set got v=%0d ovr=%0d want 1/1", v0, o0);
      end
      if (t == 399 && {v0, o0} !== 2'b10) begin
        miscompares++; $display("FAIL overrun_ack_on_snap got v=%0d ovr=%0d want 1/0", v0, o0);
      end
      if (t == 199 || t == 399) vectors++;
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(1, 0, 0);
    for (int t = 0; t < 150; t++) step(1, 1'($urandom_range(0, 4) == 0), 0);
    #2 rst = 1;
    #1;
    if (obs0 !== 50'd0) begin miscompares++; $display("FAIL async_rst u0 got %h want 0", obs0); end
    vectors++;
    if (obs1 !== 14'd0) begin miscompares++; $display("FAIL async_rst u1 got %h want 0", obs1); end
    vectors++;
    model_reset();
    step(0, 0, 0);
    rst = 0;
    step(0, 0, 0);
    step(1, 0, 0);
    for (int t = 0; t < 100; t++) begin
      step(1, 1'($urandom_range(0, 4) == 0), 0);
      if (obs0 !== exp0) begin miscompares++; $display("FAIL reentry u0 t=%0d got %h want %h", t, obs0, exp0); end
      vectors++;
      if (t == 98 && v0 !== 1'b0) begin miscompares++; $display("FAIL reentry_early got v=%0d want 0", v0); end
      if (t == 99 && v0 !== 1'b1) begin miscompares++; $display("FAIL reentry_first got v=%0d want 1", v0); end
      if (t >= 98) vectors++;
    end
  endtask

  task automatic test_saturation();
    do_reset();
    step(1, 0, 0);
    for (int t = 0; t < 30; t++) begin
      step(1, 1'(t == 5 || t == 25), 0);
      if (obs1 !== exp1) begin miscompares++; $display("FAIL sat_model u1 t=%0d got %h want %h", t, obs1, exp1); end
      vectors++;
      if (t == 14 && {v1, c1, mn1, mx1} !== {1'b1, 4'd1, 4'hF, 4'h0}) begin
        miscompares++; $display("FAIL sat_win0 got cnt=%0d min=%0d max=%0d want 1/15/0", c1, mn1, mx1);
      end
      if (t == 29 && {v1, c1, mn1, mx1} !== {1'b1, 4'd1, 4'hF, 4'hF}) begin
        miscompares++; $display("FAIL sat_win1 got cnt=%0d min=%0d max=%0d want 1/15/15", c1, mn1, mx1);
      end
      if (t == 14 || t == 29) vectors++;
    end
  endtask

  task automatic test_random();
    int hold, dens;
    bit en, p;
    do_reset();
    hold = 0;
    p = 0;
    for (int ph = 0; ph < 6; ph++) begin
      dens = $urandom_range(1, 12);
      for (int i = 0; i < 600; i++) begin
        if (hold > 0) hold--;
        else if ($urandom_range(0, 399) == 0) hold = $urandom_range(1, 5);
        en = (hold == 0);
        if ($urandom_range(0, dens) == 0) p = ~p;
        step(en, p, 1'($urandom_range(0, 3) == 0));
        if (obs0 !== exp0) begin miscompares++; $display("FAIL random u0 ph=%0d i=%0d got %h want %h", ph, i, obs0, exp0); end
        vectors++;
        if (obs1 !== exp1) begin miscompares++; $display("FAIL random u1 ph=%0d i=%0d got %h want %h", ph, i, obs1, exp1); end
        vectors++;
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1; ena = 0; pulse_in = 0; result_ack = 0;
    model_reset();
    test_reset();
    test_periodic();
    test_empty();
    test_level();
    test_overrun();
    test_async_reset();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
